// File: rtl/ids_pkg.sv
// Shared types and LFSR step for the IDS channel model.
package ids_pkg;

    typedef enum logic [1:0] {IDLE, PROC, DONE} state_t;

    typedef enum logic [1:0] {EV_COPY, EV_INS, EV_DEL, EV_SUB} event_t;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // Right-shifting Galois step: feedback taps are applied when the bit shifted out is 1.
    function automatic logic [31:0] next_lfsr(input logic [31:0] cur);
        return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 32'h0);
    endfunction

endpackage

// File: rtl/ids_lfsr.sv
// Seedable 32-bit Galois LFSR; exposes the low bits of the value it will step to next.
module ids_lfsr
    import ids_pkg::*;
#(
    parameter logic [31:0] SEED  = 32'hACE1_2024,
    parameter int          SYM_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [31:0]      load_val,
    output logic [7:0]       rnd,
    output logic [SYM_W-1:0] sym_rnd
);

    logic [31:0] state;
    logic [31:0] state_nxt;

    assign state_nxt = next_lfsr(state);
    assign rnd       = state_nxt[7:0];
    assign sym_rnd   = state_nxt[8 +: SYM_W];

    // A zero seed would lock the register, so it falls back to SEED.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED;
        end else if (load) begin
            state <= (load_val == 32'h0) ? SEED : load_val;
        end else if (en) begin
            state <= state_nxt;
        end
    end

endmodule

// File: rtl/ids_channel_stream.sv
// Streaming insertion/deletion/substitution channel: one input position per PROC cycle.
// state | meaning:  IDLE accept word | PROC resolve one position per cycle | DONE hold result
module ids_channel_stream
    import ids_pkg::*;
#(
    parameter int          K       = 5,
    parameter int          SYM_W   = 2,
    parameter int          OUT_MAX = 2 * K,
    parameter int          PI      = 2,
    parameter int          PD      = 2,
    parameter int          PS      = 2,
    parameter int          MAX_RUN = 1,
    parameter logic [31:0] SEED    = 32'hACE1_2024,
    localparam int         LEN_W   = $clog2(OUT_MAX + 1),
    localparam int         CNT_W   = $clog2(K * (MAX_RUN + 1) + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     seed_load,
    input  logic [31:0]              seed,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [K*SYM_W-1:0]       in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_MAX*SYM_W-1:0] out_data,
    output logic [LEN_W-1:0]         out_len,
    output logic [CNT_W-1:0]         ins_cnt,
    output logic [CNT_W-1:0]         del_cnt,
    output logic [CNT_W-1:0]         sub_cnt,
    output logic                     overflow
);

    localparam int IDX_W  = (K > 1) ? $clog2(K) : 1;
    localparam int RUN_W  = (MAX_RUN > 0) ? $clog2(MAX_RUN + 1) : 1;
    localparam int TH_INS = PI;
    localparam int TH_DEL = PI + PD;
    localparam int TH_SUB = PI + PD + PS;

    if (PI < 0 || PD < 0 || PS < 0 || TH_SUB > 256) begin : g_bad_thresholds
        $fatal(1, "ids_channel_stream: PI+PD+PS must lie in 0..256");
    end
    if (SEED == 32'h0 || OUT_MAX < K || SYM_W < 1 || SYM_W > 24 || MAX_RUN < 0) begin : g_bad_params
        $fatal(1, "ids_channel_stream: illegal SEED, OUT_MAX, SYM_W or MAX_RUN");
    end

    state_t                     state, state_nxt;
    event_t                     ev;
    logic [K*SYM_W-1:0]         word;
    logic [OUT_MAX*SYM_W-1:0]   obuf;
    logic [IDX_W-1:0]           idx;
    logic [RUN_W-1:0]           run;
    logic [7:0]                 rnd;
    logic [SYM_W-1:0]           sym_rnd, sym, s_eff, emit_sym;
    logic                       emit, last;
    int                         rnd_i;

    ids_lfsr #(.SEED(SEED), .SYM_W(SYM_W)) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (state == PROC),
        .load     (state == IDLE && seed_load),
        .load_val (seed),
        .rnd      (rnd),
        .sym_rnd  (sym_rnd)
    );

    assign out_data = obuf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = (state == IDLE);
        ev        = EV_COPY;
        emit      = 1'b0;
        emit_sym  = '0;
        rnd_i     = int'(rnd);
        sym       = word[int'(idx)*SYM_W +: SYM_W];
        s_eff     = (sym_rnd == '0) ? SYM_W'(1) : sym_rnd;

        // A suppressed insertion falls through to COPY, not to the deletion band.
        if (rnd_i < TH_INS)      ev = (int'(run) < MAX_RUN) ? EV_INS : EV_COPY;
        else if (rnd_i < TH_DEL) ev = EV_DEL;
        else if (rnd_i < TH_SUB) ev = EV_SUB;

        unique case (ev)
            EV_INS:  begin emit = 1'b1; emit_sym = sym_rnd;       end
            EV_SUB:  begin emit = 1'b1; emit_sym = sym ^ s_eff;   end
            EV_COPY: begin emit = 1'b1; emit_sym = sym;           end
            default: ;
        endcase
        last = (idx == IDX_W'(K - 1)) && (ev != EV_INS);

        unique case (state)
            IDLE:    if (in_valid)              state_nxt = PROC;
            PROC:    if (last)                  state_nxt = DONE;
            DONE:    if (out_valid && out_ready) state_nxt = IDLE;
            default:                            state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word      <= '0;
            obuf      <= '0;
            out_len   <= '0;
            ins_cnt   <= '0;
            del_cnt   <= '0;
            sub_cnt   <= '0;
            overflow  <= 1'b0;
            idx       <= '0;
            run       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= (state == DONE) && !(out_valid && out_ready);
            unique case (state)
                IDLE: if (in_valid) begin
                    word     <= in_data;
                    obuf     <= '0;
                    out_len  <= '0;
                    ins_cnt  <= '0;
                    del_cnt  <= '0;
                    sub_cnt  <= '0;
                    overflow <= 1'b0;
                    idx      <= '0;
                    run      <= '0;
                end
                PROC: begin
                    if (emit) begin
                        if (int'(out_len) < OUT_MAX) begin
                            obuf[int'(out_len)*SYM_W +: SYM_W] <= emit_sym;
                            out_len <= out_len + LEN_W'(1);
                        end else begin
                            overflow <= 1'b1;
                        end
                    end
                    unique case (ev)
                        EV_INS:  begin ins_cnt <= ins_cnt + CNT_W'(1); run <= run + RUN_W'(1); end
                        EV_DEL:  del_cnt <= del_cnt + CNT_W'(1);
                        EV_SUB:  sub_cnt <= sub_cnt + CNT_W'(1);
                        default: ;
                    endcase
                    if (ev != EV_INS) begin
                        run <= '0;
                        if (!last) idx <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
